// File: rtl/decode_stage_pipe.sv
// RV32I(+M) decode stage: decodes one instruction per cycle into a registered
// entry, with a 2-entry main/skid buffer between fetch and execute handshakes.
module decode_stage_pipe #(
   parameter bit          ENABLE_M   = 1'b1,
   parameter bit          ENABLE_SYS = 1'b1,
   parameter int unsigned PC_WIDTH   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [PC_WIDTH-1:0] in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PC_WIDTH-1:0] out_pc,
   output logic [4:0]          out_rs1_addr,
   output logic [4:0]          out_rs2_addr,
   output logic [4:0]          out_rd_addr,
   output logic                out_rs1_valid,
   output logic                out_rs2_valid,
   output logic                out_rd_valid,
   output logic [31:0]         out_imm,
   output logic [5:0]          out_instr_id,
   output logic                out_illegal,
   output logic [15:0]         illegal_count
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic                rs1_v;
      logic                rs2_v;
      logic                rd_v;
      logic [31:0]         imm;
      logic [5:0]          id;
      logic                illegal;
   } entry_t;

   entry_t main_q, skid_q, dec;
   logic   main_valid, skid_valid;
   logic   consume, accept;

   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm;
   logic [5:0]  id;
   logic        use_rs1, use_rs2, use_rd;

   assign opcode = in_instr[6:0];
   assign f3     = in_instr[14:12];
   assign f7     = in_instr[31:25];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u  = {in_instr[31:12], 12'b0};
   assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
   assign imm_sh = {27'b0, in_instr[24:20]};

   // Opcode/funct decode; id stays 0 for any encoding that is not recognised
   always_comb begin
      id      = 6'd0;
      imm     = 32'd0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      case (opcode)
         OPC_OP: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            use_rd  = 1'b1;
            if (f7 == 7'h00) begin
               case (f3)
                  3'd0: id = 6'd1;
                  3'd1: id = 6'd6;
                  3'd2: id = 6'd9;
                  3'd3: id = 6'd10;
                  3'd4: id = 6'd3;
                  3'd5: id = 6'd7;
                  3'd6: id = 6'd4;
                  default: id = 6'd5;
               endcase
            end else if (f7 == 7'h20) begin
               if (f3 == 3'd0) id = 6'd2;
               else if (f3 == 3'd5) id = 6'd8;
            end else if (ENABLE_M && f7 == 7'h01) begin
               id = 6'd40 + 6'(f3);
            end
         end
         OPC_OP_IMM: begin
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            imm     = imm_i;
            case (f3)
               3'd0: id = 6'd11;
               3'd2: id = 6'd18;
               3'd3: id = 6'd19;
               3'd4: id = 6'd12;
               3'd6: id = 6'd13;
               3'd7: id = 6'd14;
               3'd1: begin
                  imm = imm_sh;
                  if (f7 == 7'h00) id = 6'd15;
               end
               default: begin
                  imm = imm_sh;
                  if (f7 == 7'h00) id = 6'd16;
                  else if (f7 == 7'h20) id = 6'd17;
               end
            endcase
         end
         OPC_LOAD: begin
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            imm     = imm_i;
            case (f3)
               3'd0: id = 6'd20;
               3'd1: id = 6'd21;
               3'd2: id = 6'd22;
               3'd4: id = 6'd23;
               3'd5: id = 6'd24;
               default: id = 6'd0;
            endcase
         end
         OPC_STORE: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm     = imm_s;
            case (f3)
               3'd0: id = 6'd25;
               3'd1: id = 6'd26;
               3'd2: id = 6'd27;
               default: id = 6'd0;
            endcase
         end
         OPC_BRANCH: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm     = imm_b;
            case (f3)
               3'd0: id = 6'd28;
               3'd1: id = 6'd29;
               3'd4: id = 6'd30;
               3'd5: id = 6'd31;
               3'd6: id = 6'd32;
               3'd7: id = 6'd33;
               default: id = 6'd0;
            endcase
         end
         OPC_JAL: begin
            use_rd = 1'b1;
            imm    = imm_j;
            id     = 6'd34;
         end
         OPC_JALR: begin
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            imm     = imm_i;
            if (f3 == 3'd0) id = 6'd35;
         end
         OPC_LUI: begin
            use_rd = 1'b1;
            imm    = imm_u;
            id     = 6'd36;
         end
         OPC_AUIPC: begin
            use_rd = 1'b1;
            imm    = imm_u;
            id     = 6'd37;
         end
         OPC_SYSTEM: begin
            if (ENABLE_SYS && in_instr == 32'h00000073) id = 6'd38;
            else if (ENABLE_SYS && in_instr == 32'h00100073) id = 6'd39;
         end
         default: id = 6'd0;
      endcase
   end

   // Illegal entries carry raw addresses and pc but no flags or immediate
   always_comb begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.rs1     = in_instr[19:15];
      dec.rs2     = in_instr[24:20];
      dec.rd      = in_instr[11:7];
      dec.id      = id;
      dec.illegal = (id == 6'd0);
      if (id != 6'd0) begin
         dec.rs1_v = use_rs1;
         dec.rs2_v = use_rs2;
         dec.rd_v  = use_rd && (in_instr[11:7] != 5'd0);
         dec.imm   = imm;
      end
   end

   assign in_ready = !skid_valid;
   assign consume  = main_valid && out_ready;
   assign accept   = in_valid && !skid_valid;

   // Main/skid buffer; flush drops everything including the offered input
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q        <= '0;
         skid_q        <= '0;
         main_valid    <= 1'b0;
         skid_valid    <= 1'b0;
         illegal_count <= 16'd0;
      end else begin
         if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
         end else if (skid_valid) begin
            if (consume) begin
               main_q     <= skid_q;
               skid_valid <= 1'b0;
            end
         end else if (accept) begin
            if (!main_valid || consume) begin
               main_q     <= dec;
               main_valid <= 1'b1;
            end else begin
               skid_q     <= dec;
               skid_valid <= 1'b1;
            end
         end else if (consume) begin
            main_valid <= 1'b0;
         end
         if (!flush && consume && main_q.illegal && illegal_count != 16'hFFFF)
            illegal_count <= illegal_count + 16'd1;
      end
   end

   assign out_valid     = main_valid;
   assign out_pc        = main_q.pc;
   assign out_rs1_addr  = main_q.rs1;
   assign out_rs2_addr  = main_q.rs2;
   assign out_rd_addr   = main_q.rd;
   assign out_rs1_valid = main_q.rs1_v;
   assign out_rs2_valid = main_q.rs2_v;
   assign out_rd_valid  = main_q.rd_v;
   assign out_imm       = main_q.imm;
   assign out_instr_id  = main_q.id;
   assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: a full-featured and a base-ISA-only instance
// share stimulus and are checked against a mask/match queue model each cycle.
module tb_decode_stage_pipe;
   localparam int unsigned PCW = 32;

   logic clk = 1'b0;
   logic rst, flush, in_valid, out_ready;
   logic [31:0] in_instr;
   logic [PCW-1:0] in_pc;

   logic in_ready [2];
   logic out_valid [2];
   logic [PCW-1:0] out_pc [2];
   logic [4:0] rs1a [2], rs2a [2], rda [2];
   logic rs1v [2], rs2v [2], rdv [2];
   logic [31:0] imm [2];
   logic [5:0] id [2];
   logic ill [2];
   logic [15:0] icnt [2];

   always #5 clk = ~clk;

   decode_stage_pipe #(.ENABLE_M(1'b1), .ENABLE_SYS(1'b1), .PC_WIDTH(PCW)) u_full (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid[0]), .out_ready(out_ready),
      .out_pc(out_pc[0]), .out_rs1_addr(rs1a[0]), .out_rs2_addr(rs2a[0]), .out_rd_addr(rda[0]),
      .out_rs1_valid(rs1v[0]), .out_rs2_valid(rs2v[0]), .out_rd_valid(rdv[0]),
      .out_imm(imm[0]), .out_instr_id(id[0]), .out_illegal(ill[0]), .illegal_count(icnt[0]));

   decode_stage_pipe #(.ENABLE_M(1'b0), .ENABLE_SYS(1'b0), .PC_WIDTH(PCW)) u_base (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid[1]), .out_ready(out_ready),
      .out_pc(out_pc[1]), .out_rs1_addr(rs1a[1]), .out_rs2_addr(rs2a[1]), .out_rd_addr(rda[1]),
      .out_rs1_valid(rs1v[1]), .out_rs2_valid(rs2v[1]), .out_rd_valid(rdv[1]),
      .out_imm(imm[1]), .out_instr_id(id[1]), .out_illegal(ill[1]), .illegal_count(icnt[1]));

   typedef struct packed {
      logic [5:0]  id;
      logic [31:0] imm;
      logic        ill;
      logic        r1;
      logic        r2;
      logic        rd;
   } dec_t;

   typedef struct {
      logic [31:0]    instr;
      logic [PCW-1:0] pc;
   } pend_t;

   typedef struct {
      logic [31:0] instr;
      logic [5:0]  id;
      logic [5:0]  id_base;
      logic [31:0] imm;
      logic        ill;
      logic        r1;
      logic        r2;
      logic        rd;
   } vec_t;

   logic [31:0] mmask [48];
   logic [31:0] mmatch [48];
   pend_t q[$];
   logic [5:0] delivered[$];
   int unsigned mcnt [2];
   int n_vec = 0;
   int n_bad = 0;
   vec_t tbl [17];

   task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL dut%0d %s: got %h expected %h at %0t", d, nm, act, exp, $time);
      end
   endtask

   task automatic set_op(input int k, input logic [31:0] match, input logic [31:0] mask);
      mmatch[k] = match;
      mmask[k]  = mask;
   endtask

   // Reference decode: first mask/match hit names the instruction, format follows from its id
   function automatic dec_t ref_decode(input logic [31:0] w, input bit en_m, input bit en_sys);
      dec_t r;
      int k;
      int v;
      r = '0;
      k = 0;
      for (int i = 1; i < 48; i++)
         if (k == 0 && (w & mmask[i]) == mmatch[i]) k = i;
      if (k >= 40 && !en_m) k = 0;
      if ((k == 38 || k == 39) && !en_sys) k = 0;
      if (k == 0) begin
         r.ill = 1'b1;
         return r;
      end
      r.id = 6'(k);
      v = 0;
      if ((k >= 1 && k <= 10) || k >= 40) begin
         r.r1 = 1'b1; r.r2 = 1'b1; r.rd = 1'b1;
      end else if (k >= 15 && k <= 17) begin
         r.r1 = 1'b1; r.rd = 1'b1;
         v = int'(w[24:20]);
      end else if ((k >= 11 && k <= 24) || k == 35) begin
         r.r1 = 1'b1; r.rd = 1'b1;
         v = (w[31] ? -2048 : 0) + int'(w[30:20]);
      end else if (k >= 25 && k <= 27) begin
         r.r1 = 1'b1; r.r2 = 1'b1;
         v = (w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]);
      end else if (k >= 28 && k <= 33) begin
         r.r1 = 1'b1; r.r2 = 1'b1;
         v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      end else if (k == 34) begin
         r.rd = 1'b1;
         v = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      end else if (k == 36 || k == 37) begin
         r.rd = 1'b1;
         v = int'(w & 32'hFFFFF000);
      end
      if (w[11:7] == 5'd0) r.rd = 1'b0;
      r.imm = 32'(v);
      return r;
   endfunction

   task automatic check_outputs();
      dec_t e;
      logic [31:0] w;
      for (int d = 0; d < 2; d++) begin
         chk(d, "out_valid", 32'(out_valid[d]), 32'(q.size() > 0));
         chk(d, "in_ready", 32'(in_ready[d]), 32'(q.size() < 2));
         chk(d, "illegal_count", 32'(icnt[d]), 32'(mcnt[d]));
         if (q.size() > 0) begin
            w = q[0].instr;
            e = ref_decode(w, d == 0, d == 0);
            chk(d, "out_pc", 32'(out_pc[d]), 32'(q[0].pc));
            chk(d, "instr_id", 32'(id[d]), 32'(e.id));
            chk(d, "imm", imm[d], e.imm);
            chk(d, "illegal", 32'(ill[d]), 32'(e.ill));
            chk(d, "flags", {29'd0, rs1v[d], rs2v[d], rdv[d]}, {29'd0, e.r1, e.r2, e.rd});
            chk(d, "addrs", {17'd0, rs1a[d], rs2a[d], rda[d]}, {17'd0, w[19:15], w[24:20], w[11:7]});
         end
      end
   endtask

   task automatic check_zero();
      for (int d = 0; d < 2; d++) begin
         chk(d, "rst out_valid", 32'(out_valid[d]), 32'd0);
         chk(d, "rst in_ready", 32'(in_ready[d]), 32'd1);
         chk(d, "rst fields", {26'd0, id[d]} | imm[d] | 32'(out_pc[d]) | {16'd0, icnt[d]}, 32'd0);
         chk(d, "rst flags", {15'd0, rs1a[d], rs2a[d], rda[d], rs1v[d], rs2v[d], rdv[d], ill[d]}, 32'd0);
      end
   endtask

   // One clock: update the model with this cycle's inputs, then check after the edge
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic r, output logic acc);
      logic cons, a;
      pend_t p;
      dec_t e;
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; rst = r;
      acc = v && in_ready[0] && !fl && !r;
      if (out_valid[0] && ordy && !fl && !r) delivered.push_back(id[0]);
      if (r) begin
         q.delete();
         mcnt[0] = 0; mcnt[1] = 0;
      end else if (fl) begin
         q.delete();
      end else begin
         cons = (q.size() > 0) && ordy;
         a    = v && (q.size() < 2);
         if (cons) begin
            p = q.pop_front();
            for (int d = 0; d < 2; d++) begin
               e = ref_decode(p.instr, d == 0, d == 0);
               if (e.ill && mcnt[d] != 65535) mcnt[d]++;
            end
         end
         if (a) begin
            p.instr = ins; p.pc = pc;
            q.push_back(p);
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      logic a;
      int tries;
      set_op(1, 32'h00000033, 32'hFE00707F);  set_op(2, 32'h40000033, 32'hFE00707F);
      set_op(3, 32'h00004033, 32'hFE00707F);  set_op(4, 32'h00006033, 32'hFE00707F);
      set_op(5, 32'h00007033, 32'hFE00707F);  set_op(6, 32'h00001033, 32'hFE00707F);
      set_op(7, 32'h00005033, 32'hFE00707F);  set_op(8, 32'h40005033, 32'hFE00707F);
      set_op(9, 32'h00002033, 32'hFE00707F);  set_op(10, 32'h00003033, 32'hFE00707F);
      set_op(11, 32'h00000013, 32'h0000707F); set_op(12, 32'h00004013, 32'h0000707F);
      set_op(13, 32'h00006013, 32'h0000707F); set_op(14, 32'h00007013, 32'h0000707F);
      set_op(15, 32'h00001013, 32'hFE00707F); set_op(16, 32'h00005013, 32'hFE00707F);
      set_op(17, 32'h40005013, 32'hFE00707F); set_op(18, 32'h00002013, 32'h0000707F);
      set_op(19, 32'h00003013, 32'h0000707F); set_op(20, 32'h00000003, 32'h0000707F);
      set_op(21, 32'h00001003, 32'h0000707F); set_op(22, 32'h00002003, 32'h0000707F);
      set_op(23, 32'h00004003, 32'h0000707F); set_op(24, 32'h00005003, 32'h0000707F);
      set_op(25, 32'h00000023, 32'h0000707F); set_op(26, 32'h00001023, 32'h0000707F);
      set_op(27, 32'h00002023, 32'h0000707F); set_op(28, 32'h00000063, 32'h0000707F);
      set_op(29, 32'h00001063, 32'h0000707F); set_op(30, 32'h00004063, 32'h0000707F);
      set_op(31, 32'h00005063, 32'h0000707F); set_op(32, 32'h00006063, 32'h0000707F);
      set_op(33, 32'h00007063, 32'h0000707F); set_op(34, 32'h0000006F, 32'h0000007F);
      set_op(35, 32'h00000067, 32'h0000707F); set_op(36, 32'h00000037, 32'h0000007F);
      set_op(37, 32'h00000017, 32'h0000007F); set_op(38, 32'h00000073, 32'hFFFFFFFF);
      set_op(39, 32'h00100073, 32'hFFFFFFFF);
      for (int k = 0; k < 8; k++) set_op(40 + k, 32'h02000033 | (k << 12), 32'hFE00707F);
      mmask[0] = 32'hFFFFFFFF; mmatch[0] = 32'hFFFFFFFF;

      tbl[0]  = '{32'h00000033, 6'd1,  6'd1,  32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{32'h40000033, 6'd2,  6'd2,  32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{32'h02000033, 6'd40, 6'd0,  32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{32'hFFF00093, 6'd11, 6'd11, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{32'hFE000EE3, 6'd28, 6'd28, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{32'h00001037, 6'd36, 6'd36, 32'h00001000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{32'h00200073, 6'd0,  6'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{32'h00000000, 6'd0,  6'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{32'h40001033, 6'd0,  6'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{32'h00000073, 6'd38, 6'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{32'h40315093, 6'd17, 6'd17, 32'h00000003, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{32'h008000EF, 6'd34, 6'd34, 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{32'hFE112E23, 6'd27, 6'd27, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[13] = '{32'h0000A103, 6'd22, 6'd22, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[14] = '{32'h00003003, 6'd0,  6'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{32'h00001067, 6'd0,  6'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{32'h00000032, 6'd0,  6'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};

      // Reset, with an input offered that must be ignored
      step(1'b1, 32'h00000033, 32'h10, 1'b1, 1'b0, 1'b1, a);
      check_zero();
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, a);
      check_zero();

      // Decode table, streamed back to back: each entry visible one edge after acceptance
      for (int i = 0; i < 17; i++) begin
         step(1'b1, tbl[i].instr, 32'h1000 + 32'(i) * 4, 1'b1, 1'b0, 1'b0, a);
         chk(0, "tbl accept", 32'(a), 32'd1);
         chk(0, "tbl id", 32'(id[0]), 32'(tbl[i].id));
         chk(0, "tbl imm", imm[0], tbl[i].imm);
         chk(0, "tbl illegal", 32'(ill[0]), 32'(tbl[i].ill));
         chk(0, "tbl flags", {29'd0, rs1v[0], rs2v[0], rdv[0]}, {29'd0, tbl[i].r1, tbl[i].r2, tbl[i].rd});
         chk(0, "tbl pc", 32'(out_pc[0]), 32'h1000 + 32'(i) * 4);
         chk(1, "tbl id", 32'(id[1]), 32'(tbl[i].id_base));
         chk(1, "tbl illegal", 32'(ill[1]), 32'(tbl[i].id_base == 6'd0));
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, a);
      chk(0, "tbl count", 32'(icnt[0]), 32'd6);
      chk(1, "tbl count", 32'(icnt[1]), 32'd8);

      // Backpressure: ADD, SUB, XOR with out_ready low for 3 cycles
      delivered.delete();
      step(1'b1, 32'h00000033, 32'h200, 1'b1, 1'b0, 1'b0, a);
      step(1'b1, 32'h40000033, 32'h204, 1'b0, 1'b0, 1'b0, a);
      chk(0, "bp in_ready low", 32'(in_ready[0]), 32'd0);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 32'h00004033, 32'h208, 1'b0, 1'b0, 1'b0, a);
         chk(0, "bp hold id", 32'(id[0]), 32'd1);
         chk(0, "bp hold pc", 32'(out_pc[0]), 32'h200);
      end
      tries = 0;
      do begin
         step(1'b1, 32'h00004033, 32'h208, 1'b1, 1'b0, 1'b0, a);
         if (tries == 0) begin
            chk(0, "bp release in_ready", 32'(in_ready[0]), 32'd1);
            chk(0, "bp release id", 32'(id[0]), 32'd2);
         end
         tries++;
      end while (!a && tries < 5);
      chk(0, "bp accept bound", 32'(a), 32'd1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, a);
      chk(0, "bp delivered count", 32'(delivered.size()), 32'd3);
      if (delivered.size() == 3)
         for (int i = 0; i < 3; i++) chk(0, "bp order", 32'(delivered[i]), 32'(i + 1));

      // Flush with main and skid holding illegal entries plus an offered input
      step(1'b1, 32'h00000000, 32'h300, 1'b0, 1'b0, 1'b0, a);
      step(1'b1, 32'h00000000, 32'h304, 1'b0, 1'b0, 1'b0, a);
      chk(0, "fl full", 32'(in_ready[0]), 32'd0);
      delivered.delete();
      step(1'b1, 32'h00000033, 32'h308, 1'b1, 1'b1, 1'b0, a);
      chk(0, "fl out_valid", 32'(out_valid[0]), 32'd0);
      chk(0, "fl in_ready", 32'(in_ready[0]), 32'd1);
      for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, a);
      chk(0, "fl nothing delivered", 32'(delivered.size()), 32'd0);
      chk(0, "fl count", 32'(icnt[0]), 32'd6);
      chk(1, "fl count", 32'(icnt[1]), 32'd8);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] w;
         int k;
         if ($urandom_range(0, 3) == 0) w = $urandom;
         else begin
            k = $urandom_range(1, 47);
            w = mmatch[k] | ($urandom & ~mmask[k]);
         end
         step(1'($urandom_range(0, 3) != 0), w, $urandom, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 31) == 0), 1'b0, a);
      end

      // Saturation of illegal_count
      for (int i = 0; i < 65537; i++) step(1'b1, 32'h00000000, 32'(i), 1'b1, 1'b0, 1'b0, a);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, a);
      chk(0, "sat count", 32'(icnt[0]), 32'h0000FFFF);
      chk(1, "sat count", 32'(icnt[1]), 32'h0000FFFF);

      // Reset (with flush) during backpressure discards both entries
      step(1'b1, 32'h00000033, 32'h400, 1'b0, 1'b0, 1'b0, a);
      step(1'b1, 32'h40000033, 32'h404, 1'b0, 1'b0, 1'b0, a);
      chk(0, "rbp full", 32'(in_ready[0]), 32'd0);
      step(1'b1, 32'h00004033, 32'h408, 1'b0, 1'b1, 1'b1, a);
      check_zero();
      step(1'b1, 32'h00004033, 32'h408, 1'b1, 1'b0, 1'b1, a);
      check_zero();
      delivered.delete();
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, a);
      chk(0, "rbp nothing delivered", 32'(delivered.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
